// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus master: size encodings,
// FSM states, request latch layout, region match and lane formatting.
package lsu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned BE_W       = 4;
  localparam int unsigned ADDR_MAX_W = 64;

  localparam logic [1:0] HB_BYTE = 2'b00;
  localparam logic [1:0] HB_HALF = 2'b01;
  localparam logic [1:0] HB_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic       we;
    logic [1:0] hb;
    logic       ul;
    logic [1:0] off;
  } req_t;

  function automatic logic region_hit(input logic [ADDR_MAX_W-1:0] addr,
                                      input logic [ADDR_MAX_W-1:0] base,
                                      input logic [ADDR_MAX_W-1:0] mask);
    return (addr & mask) == base;
  endfunction

  function automatic logic misaligned(input logic [1:0] hb, input logic [1:0] off);
    logic res;
    res = 1'b1;
    case (hb)
      HB_BYTE: res = 1'b0;
      HB_HALF: res = off[0];
      HB_WORD: res = (off != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [BE_W-1:0] byte_en(input logic [1:0] hb, input logic [1:0] off);
    logic [BE_W-1:0] res;
    res = 4'b1111;
    case (hb)
      HB_BYTE: res = 4'b0001 << off;
      HB_HALF: res = 4'b0011 << off;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [1:0] hb,
                                                   input logic [DATA_W-1:0] wd);
    logic [DATA_W-1:0] res;
    res = wd;
    case (hb)
      HB_BYTE: res = {4{wd[7:0]}};
      HB_HALF: res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

  // Right-align the addressed lane, then sign- or zero-extend to 32 bits.
  function automatic logic [DATA_W-1:0] load_extend(input logic [1:0] hb, input logic ul,
                                                    input logic [DATA_W-1:0] word,
                                                    input logic [1:0] off);
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] res;
    sh  = word >> {off, 3'b000};
    res = sh;
    case (hb)
      HB_BYTE: res = ul ? {24'h0, sh[7:0]}   : {{24{sh[7]}}, sh[7:0]};
      HB_HALF: res = ul ? {16'h0, sh[15:0]}  : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_addr_decode.sv
// Address region decoder: one-hot hit vector where the lowest matching slot wins.
module lsu_addr_decode
  import lsu_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES = 3,
  parameter int unsigned                  ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = {32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = {32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_F000}
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [NUM_SLAVES-1:0] hit_o,
  output logic                  any_hit_o
);

  logic [NUM_SLAVES-1:0] raw_hit;

  always_comb begin
    raw_hit = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      raw_hit[i] = region_hit(ADDR_MAX_W'(addr_i),
                              ADDR_MAX_W'(SLV_BASE[i*ADDR_W +: ADDR_W]),
                              ADDR_MAX_W'(SLV_MASK[i*ADDR_W +: ADDR_W]));
    end
  end

  // Isolate the lowest set bit so overlapping regions resolve to the lowest slot.
  assign hit_o     = raw_hit & (~raw_hit + NUM_SLAVES'(1));
  assign any_hit_o = |raw_hit;

endmodule

// File: rtl/lsu_bus_master.sv
// Multi-cycle load/store unit: req/ack slave bus with region decode,
// lane replication, load extension and misalign/unmapped/timeout errors.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES = 3,
  parameter int unsigned                  ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = {32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK   = {32'hFFFF_FFF0, 32'hFFFF_F000, 32'hFFFF_F000},
  parameter int unsigned                  TIMEOUT    = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         core_req_i,
  output logic                         core_ready_o,
  input  logic                         core_we_i,
  input  logic [1:0]                   core_hb_i,
  input  logic                         core_ul_i,
  input  logic [ADDR_W-1:0]            core_addr_i,
  input  logic [DATA_W-1:0]            core_wdata_i,
  output logic                         core_rvalid_o,
  output logic [DATA_W-1:0]            core_rdata_o,
  output logic                         core_err_o,
  output logic [NUM_SLAVES-1:0]        bus_cs_o,
  output logic [ADDR_W-1:0]            bus_addr_o,
  output logic                         bus_we_o,
  output logic [BE_W-1:0]              bus_be_o,
  output logic [DATA_W-1:0]            bus_wdata_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] bus_rdata_i,
  input  logic [NUM_SLAVES-1:0]        bus_ack_i
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                state_q, state_d;
  req_t                  req_q, req_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [NUM_SLAVES-1:0] cs_q, cs_d;
  logic [ADDR_W-1:0]     baddr_q, baddr_d;
  logic                  bwe_q, bwe_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_W-1:0]     bwdata_q, bwdata_d;

  logic [NUM_SLAVES-1:0] hit;
  logic                  any_hit;
  logic                  req_err;
  logic                  sel_ack;
  logic                  timed_out;
  logic [DATA_W-1:0]     sel_rdata;

  lsu_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES),
    .ADDR_W    (ADDR_W),
    .SLV_BASE  (SLV_BASE),
    .SLV_MASK  (SLV_MASK)
  ) u_decode (
    .addr_i   (core_addr_i),
    .hit_o    (hit),
    .any_hit_o(any_hit)
  );

  assign req_err   = misaligned(core_hb_i, core_addr_i[1:0]) || !any_hit;
  assign sel_ack   = |(bus_ack_i & cs_q);
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (cs_q[i]) sel_rdata = sel_rdata | bus_rdata_i[DATA_W*i +: DATA_W];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (core_req_i) state_d = req_err ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (sel_ack || timed_out) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Bus outputs default to 0 and are only held while the access is in flight.
  always_comb begin
    req_d    = req_q;
    cnt_d    = '0;
    ready_d  = (state_d == ST_IDLE);
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    rdata_d  = '0;
    cs_d     = '0;
    baddr_d  = '0;
    bwe_d    = 1'b0;
    be_d     = '0;
    bwdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (core_req_i) begin
          req_d.we  = core_we_i;
          req_d.hb  = core_hb_i;
          req_d.ul  = core_ul_i;
          req_d.off = core_addr_i[1:0];
          if (req_err) begin
            rvalid_d = 1'b1;
            err_d    = 1'b1;
          end else begin
            cs_d     = hit;
            baddr_d  = {core_addr_i[ADDR_W-1:2], 2'b00};
            bwe_d    = core_we_i;
            be_d     = byte_en(core_hb_i, core_addr_i[1:0]);
            bwdata_d = store_data(core_hb_i, core_wdata_i);
          end
        end
      end
      ST_ACCESS: begin
        if (sel_ack) begin
          rvalid_d = 1'b1;
          if (!req_q.we) rdata_d = load_extend(req_q.hb, req_q.ul, sel_rdata, req_q.off);
        end else if (timed_out) begin
          rvalid_d = 1'b1;
          err_d    = 1'b1;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          cs_d     = cs_q;
          baddr_d  = baddr_q;
          bwe_d    = bwe_q;
          be_d     = be_q;
          bwdata_d = bwdata_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cs_q     <= '0;
      baddr_q  <= '0;
      bwe_q    <= 1'b0;
      be_q     <= '0;
      bwdata_q <= '0;
    end else begin
      req_q    <= req_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      baddr_q  <= baddr_d;
      bwe_q    <= bwe_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
    end
  end

  assign core_ready_o  = ready_q;
  assign core_rvalid_o = rvalid_q;
  assign core_err_o    = err_q;
  assign core_rdata_o  = rdata_q;
  assign bus_cs_o      = cs_q;
  assign bus_addr_o    = baddr_q;
  assign bus_we_o      = bwe_q;
  assign bus_be_o      = be_q;
  assign bus_wdata_o   = bwdata_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Randomized and directed bench for lsu_bus_master against a behavioural access model.
module tb_lsu_bus_master;

  localparam int NS  = 3;
  localparam int TMO = 16;
  localparam logic [31:0] BASE [NS] = '{32'h0000_0000, 32'h0001_0000, 32'h0002_0000};
  localparam logic [31:0] MASK [NS] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FFF0};

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           core_req_i;
  logic           core_ready_o;
  logic           core_we_i;
  logic [1:0]     core_hb_i;
  logic           core_ul_i;
  logic [31:0]    core_addr_i;
  logic [31:0]    core_wdata_i;
  logic           core_rvalid_o;
  logic [31:0]    core_rdata_o;
  logic           core_err_o;
  logic [NS-1:0]  bus_cs_o;
  logic [31:0]    bus_addr_o;
  logic           bus_we_o;
  logic [3:0]     bus_be_o;
  logic [31:0]    bus_wdata_o;
  logic [NS*32-1:0] bus_rdata_i;
  logic [NS-1:0]  bus_ack_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  lsu_bus_master #(.NUM_SLAVES(NS), .ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_ready_o(core_ready_o),
    .core_we_i(core_we_i), .core_hb_i(core_hb_i), .core_ul_i(core_ul_i),
    .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o), .core_err_o(core_err_o),
    .bus_cs_o(bus_cs_o), .bus_addr_o(bus_addr_o), .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"},  32'(core_ready_o), 32'd1);
    check_eq({tag, "_rvalid"}, 32'(core_rvalid_o), 32'd0);
    check_eq({tag, "_err"},    32'(core_err_o), 32'd0);
    check_eq({tag, "_rdata"},  core_rdata_o, 32'd0);
    check_eq({tag, "_cs"},     32'(bus_cs_o), 32'd0);
    check_eq({tag, "_addr"},   bus_addr_o, 32'd0);
    check_eq({tag, "_we"},     32'(bus_we_o), 32'd0);
    check_eq({tag, "_be"},     32'(bus_be_o), 32'd0);
    check_eq({tag, "_wdata"},  bus_wdata_o, 32'd0);
  endtask

  // delay: wait cycles before the selected slave acks (<0 = never);
  // spur: 0 none, 1 random, 2 every cycle acks from unselected slaves.
  task automatic run_access(input logic we, input logic [1:0] hb, input logic ul,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int delay, input int spur, input logic [31:0] sel_rd);
    int          slot;
    int          off;
    int          size;
    int          exp_cyc;
    logic        exp_err;
    logic        resp_err;
    logic [31:0] lane;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [NS-1:0] sel;
    logic [NS-1:0] ack;

    slot = -1;
    for (int s = 0; s < NS; s++)
      if (slot < 0 && ((addr & MASK[s]) == BASE[s])) slot = s;
    off  = int'(addr % 32'd4);
    size = (hb == 2'd3) ? 0 : (1 << hb);
    exp_err = (slot < 0) || (size == 0);
    if (size != 0 && (addr % size) != 0) exp_err = 1'b1;
    sel = (slot >= 0) ? NS'(1 << slot) : '0;

    for (int s = 0; s < NS; s++) bus_rdata_i[32*s +: 32] = $urandom;
    if (slot >= 0) bus_rdata_i[32*slot +: 32] = sel_rd;

    resp_err = exp_err;
    if (exp_err)                          exp_cyc = 1;
    else if (delay >= 0 && delay < TMO)   exp_cyc = delay + 2;
    else begin exp_cyc = TMO + 1; resp_err = 1'b1; end

    lane = sel_rd >> (8 * off);
    case (hb)
      2'd0: begin
        exp_rd = lane & 32'hFF;
        if (!ul && exp_rd >= 32'd128) exp_rd = exp_rd - 32'd256;
      end
      2'd1: begin
        exp_rd = lane & 32'hFFFF;
        if (!ul && exp_rd >= 32'd32768) exp_rd = exp_rd - 32'd65536;
      end
      default: exp_rd = lane;
    endcase
    if (we || resp_err) exp_rd = 32'd0;
    exp_be = 4'(((hb == 2'd0) ? 1 : (hb == 2'd1) ? 3 : 15) << off);
    exp_wd = (hb == 2'd0) ? wd[7:0] * 32'h0101_0101 :
             (hb == 2'd1) ? wd[15:0] * 32'h0001_0001 : wd;

    @(negedge clk_i);
    check_eq("ready_idle", 32'(core_ready_o), 32'd1);
    check_eq("rvalid_pulse", 32'(core_rvalid_o), 32'd0);
    core_req_i = 1'b1; core_we_i = we; core_hb_i = hb; core_ul_i = ul;
    core_addr_i = addr; core_wdata_i = wd;
    @(negedge clk_i);
    core_req_i = 1'b0;
    core_we_i = 1'b0; core_hb_i = 2'd0; core_ul_i = 1'b0; core_addr_i = $urandom; core_wdata_i = $urandom;

    for (int c = 1; c <= TMO + 4; c++) begin
      if (c > 1) @(negedge clk_i);
      if (c == exp_cyc) begin
        check_eq("rvalid", 32'(core_rvalid_o), 32'd1);
        check_eq("err", 32'(core_err_o), 32'(resp_err));
        check_eq("rdata", core_rdata_o, exp_rd);
        check_eq("resp_cs", 32'(bus_cs_o), 32'd0);
        check_eq("resp_ready", 32'(core_ready_o), 32'd0);
        break;
      end
      check_eq("rvalid_early", 32'(core_rvalid_o), 32'd0);
      if (c == 1) begin
        check_eq("cs", 32'(bus_cs_o), 32'(sel));
        check_eq("bus_addr", bus_addr_o, addr & 32'hFFFF_FFFC);
        check_eq("bus_we", 32'(bus_we_o), 32'(we));
        check_eq("be", 32'(bus_be_o), 32'(exp_be));
        check_eq("wdata", bus_wdata_o, exp_wd);
        check_eq("busy_ready", 32'(core_ready_o), 32'd0);
      end
      ack = '0;
      if (spur == 1) ack = NS'($urandom) & ~sel;
      if (spur == 2) ack = ~sel;
      if (c == 1 + delay) ack = ack | sel;
      bus_ack_i = ack;
    end
    bus_ack_i = '0;
  endtask

  task automatic random_access();
    int          slot;
    logic [1:0]  hb;
    logic [31:0] addr;
    int          delay;
    int          r;
    hb   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    slot = $urandom_range(0, NS);
    if (slot == NS) addr = 32'h0005_0000 + ($urandom & 32'h0000_FFFF);
    else            addr = BASE[slot] + ($urandom & ~MASK[slot]);
    if ($urandom_range(0, 3) != 0 && hb != 2'd3) addr = addr & ~((32'd1 << hb) - 32'd1);
    r = $urandom_range(0, 11);
    if      (r == 0) delay = TMO - 1;
    else if (r == 1) delay = TMO;
    else if (r == 2) delay = -1;
    else             delay = $urandom_range(0, 4);
    run_access(1'($urandom), hb, 1'($urandom), addr, $urandom, delay,
               $urandom_range(0, 1), $urandom);
  endtask

  initial begin
    rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_hb_i = 2'd0; core_ul_i = 1'b0;
    core_addr_i = '0; core_wdata_i = '0; bus_rdata_i = '0; bus_ack_i = '0;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_i = 1'b0;

    run_access(1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0,        0, 0, 32'hDEAD_BEEF);
    run_access(1'b0, 2'd0, 1'b0, 32'h0001_0003, 32'h0,        0, 0, 32'h8000_0000);
    run_access(1'b0, 2'd0, 1'b1, 32'h0001_0003, 32'h0,        0, 0, 32'h8000_0000);
    run_access(1'b1, 2'd1, 1'b0, 32'h0001_0002, 32'h1234_ABCD, 1, 0, 32'h5555_AAAA);
    run_access(1'b0, 2'd2, 1'b0, 32'h0001_0001, 32'h0,        0, 0, 32'h1);
    run_access(1'b0, 2'd2, 1'b0, 32'h0005_0000, 32'h0,        0, 0, 32'h1);
    run_access(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        2, 1, 32'h9ABC_7123);
    run_access(1'b0, 2'd1, 1'b0, 32'h0000_0100, 32'h0,        2, 1, 32'h9ABC_7123);
    run_access(1'b0, 2'd2, 1'b0, 32'h0002_0004, 32'h0,       -1, 2, 32'h1111_2222);
    run_access(1'b0, 2'd2, 1'b0, 32'h0002_0008, 32'h0, TMO - 1, 2, 32'h3333_4444);

    // Reset pulse while a RAM load is waiting for its ack.
    @(negedge clk_i);
    core_req_i = 1'b1; core_we_i = 1'b0; core_hb_i = 2'd2; core_addr_i = 32'h0001_0008;
    @(negedge clk_i);
    core_req_i = 1'b0;
    check_eq("rst_pre_cs", 32'(bus_cs_o), 32'd2);
    @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1 check_all_zero("rst_mid");
    @(negedge clk_i);
    rst_i = 1'b0;
    run_access(1'b0, 2'd2, 1'b0, 32'h0001_0008, 32'h0, 3, 0, 32'hCAFE_F00D);

    for (int n = 0; n < 120; n++) random_access();

    @(negedge clk_i);
    check_eq("final_rvalid", 32'(core_rvalid_o), 32'd0);
    check_eq("final_ready", 32'(core_ready_o), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
